// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction read request/response channel
// plus the valid/ready handshake toward decode.
interface instr_fetch_if;
    logic        instr_req_valid_o;
    logic [31:0] instr_req_addr_o;
    logic        instr_req_ready_i;
    logic        instr_resp_valid_i;
    logic [31:0] instr_resp_data_i;
    logic        instr_resp_error_i;
    logic        fetch_valid_o;
    logic        fetch_ready_i;
    logic [31:0] fetch_instr_o;
    logic        fetch_fault_o;
    logic [31:0] fault_pc_o;

    modport master (
        output instr_req_valid_o,
        output instr_req_addr_o,
        input  instr_req_ready_i,
        input  instr_resp_valid_i,
        input  instr_resp_data_i,
        input  instr_resp_error_i,
        output fetch_valid_o,
        input  fetch_ready_i,
        output fetch_instr_o,
        output fetch_fault_o,
        output fault_pc_o
    );

    modport slave (
        input  instr_req_valid_o,
        input  instr_req_addr_o,
        output instr_req_ready_i,
        output instr_resp_valid_i,
        output instr_resp_data_i,
        output instr_resp_error_i,
        input  fetch_valid_o,
        output fetch_ready_i,
        input  fetch_instr_o,
        input  fetch_fault_o,
        input  fault_pc_o
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch front end: credit-limited bus reads, response buffer,
// decode handshake, redirect flush with in-flight discard, fault reporting.
module instr_fetch #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUT    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          jump_i,
    input  logic [31:0]   pc_reset_i,
    input  logic [31:0]   pc_jump_i,
    instr_fetch_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUT);

    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_e;

    state_e state_q, state_d;
    logic [31:0]   pc_q, pc_d, rpc_q, rpc_d;
    logic [CW-1:0] out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [31:0]   data_q [FIFO_DEPTH];
    logic [31:0]   epc_q  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] err_q;

    logic run, empty, head_err, redir, req, acc, dec;
    logic keep, pop, fault;
    logic [CW:0] credit;

    always_comb begin
        run      = state_q == RUN;
        empty    = cnt_q == '0;
        head_err = ~empty & err_q[rp_q];
        redir    = jump_i & (state_q != BOOT);
        credit   = {1'b0, out_q} + {1'b0, cnt_q};
        req      = run & ~jump_i & (out_q < MAXO_C)
                 & (credit < DEPTH_C);
        acc      = req & bus.instr_req_ready_i;
        // Responses with nothing tracked (pre-reset traffic) are ignored.
        dec      = bus.instr_resp_valid_i & (out_q != '0);
        fault    = run & ~jump_i & head_err;
        keep     = dec & run & ~jump_i & ~fault & (disc_q == '0);
        pop      = run & ~jump_i & ~empty & ~head_err
                 & bus.fetch_ready_i;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rpc_d   = rpc_q;
        disc_d  = disc_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        out_d   = out_q + CW'(acc) - CW'(dec);
        cnt_d   = cnt_q + CW'(keep) - CW'(pop);
        if (dec && disc_q != '0) disc_d = disc_q - CW'(1);
        if (acc) pc_d = pc_q + 32'd4;
        if (keep) begin
            wp_d  = wp_q + PW'(1);
            rpc_d = rpc_q + 32'd4;
        end
        if (pop) rp_d = rp_q + PW'(1);
        unique case (state_q)
            BOOT: begin
                pc_d    = pc_reset_i;
                rpc_d   = pc_reset_i;
                state_d = RUN;
            end
            RUN:     if (fault) state_d = FAULT;
            FAULT:   state_d = FAULT;
            default: state_d = BOOT;
        endcase
        if (fault) begin
            cnt_d = '0;
            wp_d  = '0;
            rp_d  = '0;
        end
        // Everything still in flight after this cycle belongs to the old path.
        if (redir) begin
            pc_d    = {pc_jump_i[31:2], 2'b00};
            rpc_d   = {pc_jump_i[31:2], 2'b00};
            disc_d  = out_d;
            cnt_d   = '0;
            wp_d    = '0;
            rp_d    = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_q    <= '0;
            rpc_q   <= '0;
            out_q   <= '0;
            disc_q  <= '0;
            cnt_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            err_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                epc_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rpc_q   <= rpc_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
            cnt_q   <= cnt_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            if (keep) begin
                data_q[wp_q] <= bus.instr_resp_data_i;
                epc_q[wp_q]  <= rpc_q;
                err_q[wp_q]  <= bus.instr_resp_error_i;
            end
        end
    end

    assign bus.instr_req_valid_o = req;
    assign bus.instr_req_addr_o  = pc_q;
    assign bus.fetch_valid_o     = run & ~jump_i & ~empty & ~head_err;
    assign bus.fetch_instr_o     = empty ? '0 : data_q[rp_q];
    assign bus.fetch_fault_o     = fault;
    assign bus.fault_pc_o        = fault ? epc_q[rp_q] : '0;
endmodule
